dut_driver: RTL and testbench

DUT_DRIVER -- requirements
Module: dut_driver

---
 rtl/dut_driver_if.sv | 43 ++++
 rtl/dut_driver.sv | 146 ++++++++++++++
 tb/tb_dut_driver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dut_driver_if.sv
// Command, downstream read/write and response signals of dut_driver.
// "slave" is the dut_driver side; "master" is the side that drives it.
interface dut_driver_if;
    logic       cmd_en;
    logic       cmd_is_read;
    logic [2:0] cmd_address;
    logic       cmd_data;
    logic       cmd_rdy;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;
    logic       resp_en;
    logic [2:0] resp_address;
    logic       resp_data;
    logic       resp_rdy;

    modport slave (
        input  cmd_en, cmd_is_read, cmd_address, cmd_data,
        output cmd_rdy,
        output write_address, write_data, write_en,
        input  write_rdy,
        output read_address, read_en,
        input  read_data, read_rdy,
        input  resp_en,
        output resp_address, resp_data, resp_rdy
    );

    modport master (
        output cmd_en, cmd_is_read, cmd_address, cmd_data,
        input  cmd_rdy,
        input  write_address, write_data, write_en,
        output write_rdy,
        input  read_address, read_en,
        output read_data, read_rdy,
        output resp_en,
        input  resp_address, resp_data, resp_rdy
    );
endinterface

// File: rtl/dut_driver.sv
// In-order command driver: 4-entry command FIFO issuing to write/read methods, 4-entry response FIFO.
// Optional DUT_DRIVER_STATS_EN adds saturating wr_count/rd_count issue counters.
module dut_driver (
    input  logic        CLK,
    input  logic        RST_N,
    dut_driver_if.slave bus
`ifdef DUT_DRIVER_STATS_EN
    ,
    output logic [7:0]  wr_count,
    output logic [7:0]  rd_count
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } head_state_e;

    logic       cmd_is_read_r [4];
    logic [2:0] cmd_addr_r    [4];
    logic       cmd_data_r    [4];
    logic [1:0] cmd_wr_ptr_r;
    logic [1:0] cmd_rd_ptr_r;
    logic [2:0] cmd_count_r;

    logic [2:0] resp_addr_r [4];
    logic       resp_data_r [4];
    logic [1:0] resp_wr_ptr_r;
    logic [1:0] resp_rd_ptr_r;
    logic [2:0] resp_count_r;

    head_state_e head_state_s;
    logic        head_is_read_s;
    logic        cmd_rdy_s;
    logic        cmd_push_s;
    logic        cmd_pop_s;
    logic        write_go_s;
    logic        read_go_s;
    logic        resp_rdy_s;
    logic        resp_pop_s;

    // Classify the head entry and derive the issue strobes; low RST_N forces everything idle.
    always_comb begin
        head_is_read_s = cmd_is_read_r[cmd_rd_ptr_r];
        cmd_rdy_s      = RST_N && (cmd_count_r < 3'd4);
        resp_rdy_s     = RST_N && (resp_count_r != 3'd0);
        head_state_s   = ST_IDLE;
        write_go_s     = 1'b0;
        read_go_s      = 1'b0;
        if (!RST_N || (cmd_count_r == 3'd0)) begin
            head_state_s = ST_IDLE;
        end else if (head_is_read_s ? (bus.read_rdy && (resp_count_r < 3'd4)) : bus.write_rdy) begin
            head_state_s = ST_ISSUE;
        end else begin
            head_state_s = ST_STALL;
        end
        case (head_state_s)
            ST_ISSUE: begin
                if (head_is_read_s) begin
                    read_go_s = 1'b1;
                end else begin
                    write_go_s = 1'b1;
                end
            end
            default: begin
                write_go_s = 1'b0;
                read_go_s  = 1'b0;
            end
        endcase
        cmd_push_s = bus.cmd_en && cmd_rdy_s;
        cmd_pop_s  = write_go_s || read_go_s;
        resp_pop_s = bus.resp_en && resp_rdy_s;
    end

    assign bus.cmd_rdy       = cmd_rdy_s;
    assign bus.write_address = cmd_addr_r[cmd_rd_ptr_r];
    assign bus.write_data    = cmd_data_r[cmd_rd_ptr_r];
    assign bus.write_en      = write_go_s;
    assign bus.read_address  = cmd_addr_r[cmd_rd_ptr_r];
    assign bus.read_en       = read_go_s;
    assign bus.resp_address  = resp_addr_r[resp_rd_ptr_r];
    assign bus.resp_data     = resp_data_r[resp_rd_ptr_r];
    assign bus.resp_rdy      = resp_rdy_s;

    // Command FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cmd_wr_ptr_r <= 2'd0;
            cmd_rd_ptr_r <= 2'd0;
            cmd_count_r  <= 3'd0;
        end else begin
            if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + 2'd1;
            if (cmd_pop_s)  cmd_rd_ptr_r <= cmd_rd_ptr_r + 2'd1;
            cmd_count_r <= cmd_count_r + {2'b00, cmd_push_s} - {2'b00, cmd_pop_s};
        end
    end

    // Command FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge CLK) begin
        if (cmd_push_s) begin
            cmd_is_read_r[cmd_wr_ptr_r] <= bus.cmd_is_read;
            cmd_addr_r[cmd_wr_ptr_r]    <= bus.cmd_address;
            cmd_data_r[cmd_wr_ptr_r]    <= bus.cmd_data;
        end
    end

    // Response FIFO pointers and occupancy; a read issue pushes, resp_en pops.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            resp_wr_ptr_r <= 2'd0;
            resp_rd_ptr_r <= 2'd0;
            resp_count_r  <= 3'd0;
        end else begin
            if (read_go_s)  resp_wr_ptr_r <= resp_wr_ptr_r + 2'd1;
            if (resp_pop_s) resp_rd_ptr_r <= resp_rd_ptr_r + 2'd1;
            resp_count_r <= resp_count_r + {2'b00, read_go_s} - {2'b00, resp_pop_s};
        end
    end

    // Response FIFO storage captures the issued address with the returned data.
    always_ff @(posedge CLK) begin
        if (read_go_s) begin
            resp_addr_r[resp_wr_ptr_r] <= cmd_addr_r[cmd_rd_ptr_r];
            resp_data_r[resp_wr_ptr_r] <= bus.read_data;
        end
    end

`ifdef DUT_DRIVER_STATS_EN
    logic [7:0] wr_count_r;
    logic [7:0] rd_count_r;

    // Saturating issue counters.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_count_r <= 8'd0;
            rd_count_r <= 8'd0;
        end else begin
            if (write_go_s && (wr_count_r != 8'hFF)) wr_count_r <= wr_count_r + 8'd1;
            if (read_go_s && (rd_count_r != 8'hFF))  rd_count_r <= rd_count_r + 8'd1;
        end
    end

    assign wr_count = wr_count_r;
    assign rd_count = rd_count_r;
`endif
endmodule

// File: tb/tb_dut_driver.sv
// Self-checking bench for dut_driver: a per-cycle vector table plus directed multi-cycle sequences.
module tb_dut_driver;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    dut_driver_if bus();
`ifdef DUT_DRIVER_STATS_EN
    logic [7:0] wr_count;
    logic [7:0] rd_count;
`endif

    dut_driver u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
`ifdef DUT_DRIVER_STATS_EN
        ,
        .wr_count (wr_count),
        .rd_count (rd_count)
`endif
    );

    typedef struct {
        logic       cmd_en;
        logic       is_rd;
        logic [2:0] addr;
        logic       data;
        logic       wrdy;
        logic       rrdy;
        logic       rdata;
        logic       resp_en;
        logic       x_cmd_rdy;
        logic       x_wen;
        logic [2:0] x_waddr;
        logic       x_wdata;
        logic       x_ren;
        logic [2:0] x_raddr;
        logic       x_resp_rdy;
        logic [2:0] x_resp_addr;
        logic       x_resp_data;
    } vec_t;

    vec_t vecs [11];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic en, input logic rd, input logic [2:0] a, input logic d);
        bus.cmd_en      = en;
        bus.cmd_is_read = rd;
        bus.cmd_address = a;
        bus.cmd_data    = d;
    endtask

    initial begin
        int pulses;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        bus.write_rdy = 1'b0;
        bus.read_rdy  = 1'b0;
        bus.read_data = 1'b0;
        bus.resp_en   = 1'b0;

        // W5/1 then R5, followed by a blocked read ahead of a ready write.
        vecs[0]  = '{1'b1,1'b0,3'd5,1'b1, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[1]  = '{1'b1,1'b1,3'd5,1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,3'd5,1'b1,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[2]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b1,3'd5,1'b0,3'd0,1'b0};
        vecs[3]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,3'd5,1'b1};
        vecs[4]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[5]  = '{1'b1,1'b1,3'd2,1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[6]  = '{1'b1,1'b0,3'd3,1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[7]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};
        vecs[8]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b1,3'd2,1'b0,3'd0,1'b0};
        vecs[9]  = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,3'd3,1'b0,1'b0,3'd0,1'b1,3'd2,1'b0};
        vecs[10] = '{1'b0,1'b0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0};

        // Initial reset.
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_cmd_rdy", bus.cmd_rdy, 8'd0);
        check("rst_resp_rdy", bus.resp_rdy, 8'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("post_rst_cmd_rdy", bus.cmd_rdy, 8'd1);
        check("post_rst_resp_rdy", bus.resp_rdy, 8'd0);
        @(negedge CLK);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].cmd_en, vecs[i].is_rd, vecs[i].addr, vecs[i].data);
            bus.write_rdy = vecs[i].wrdy;
            bus.read_rdy  = vecs[i].rrdy;
            bus.read_data = vecs[i].rdata;
            bus.resp_en   = vecs[i].resp_en;
            #1;
            check($sformatf("v%0d_cmd_rdy", i), bus.cmd_rdy, 8'(vecs[i].x_cmd_rdy));
            check($sformatf("v%0d_wen", i), bus.write_en, 8'(vecs[i].x_wen));
            check($sformatf("v%0d_ren", i), bus.read_en, 8'(vecs[i].x_ren));
            check($sformatf("v%0d_resp_rdy", i), bus.resp_rdy, 8'(vecs[i].x_resp_rdy));
            if (vecs[i].x_wen) begin
                check($sformatf("v%0d_waddr", i), bus.write_address, 8'(vecs[i].x_waddr));
                check($sformatf("v%0d_wdata", i), bus.write_data, 8'(vecs[i].x_wdata));
            end
            if (vecs[i].x_ren)
                check($sformatf("v%0d_raddr", i), bus.read_address, 8'(vecs[i].x_raddr));
            if (vecs[i].x_resp_rdy) begin
                check($sformatf("v%0d_resp_addr", i), bus.resp_address, 8'(vecs[i].x_resp_addr));
                check($sformatf("v%0d_resp_data", i), bus.resp_data, 8'(vecs[i].x_resp_data));
            end
            @(negedge CLK);
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        bus.resp_en = 1'b0;

        // Reset with a pending response and three queued writes.
        bus.write_rdy = 1'b0;
        bus.read_rdy  = 1'b1;
        bus.read_data = 1'b1;
        drive(1'b1, 1'b1, 3'd6, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'd1, 1'b0);
        @(negedge CLK);
        bus.read_rdy = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'd3, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        check("pre_rst_resp_rdy", bus.resp_rdy, 8'd1);
        check("pre_rst_cmd_rdy", bus.cmd_rdy, 8'd1);
        RST_N = 1'b0;
        bus.write_rdy = 1'b1;
        bus.read_rdy  = 1'b1;
        #1;
        check("in_rst_wen", bus.write_en, 8'd0);
        check("in_rst_cmd_rdy", bus.cmd_rdy, 8'd0);
        check("in_rst_resp_rdy", bus.resp_rdy, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rel_cmd_rdy", bus.cmd_rdy, 8'd1);
        check("rel_resp_rdy", bus.resp_rdy, 8'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rel%0d_wen", c), bus.write_en, 8'd0);
            check($sformatf("rel%0d_ren", c), bus.read_en, 8'd0);
            check($sformatf("rel%0d_resp_rdy", c), bus.resp_rdy, 8'd0);
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);

        // Full command FIFO: five pushes with write_rdy low, then drain.
        bus.write_rdy = 1'b0;
        bus.read_rdy  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 3'(i + 1), 1'(i));
            #1;
            check($sformatf("full_push%0d_cmd_rdy", i), bus.cmd_rdy, (i < 4) ? 8'd1 : 8'd0);
            @(negedge CLK);
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        bus.write_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (j == 0) check("full_pop_cmd_rdy", bus.cmd_rdy, 8'd0);
            check($sformatf("drain%0d_wen", j), bus.write_en, 8'd1);
            check($sformatf("drain%0d_waddr", j), bus.write_address, 8'(j + 1));
            check($sformatf("drain%0d_wdata", j), bus.write_data, 8'(j % 2));
            @(negedge CLK);
        end
        #1;
        check("drained_wen", bus.write_en, 8'd0);
        check("drained_cmd_rdy", bus.cmd_rdy, 8'd1);
        @(negedge CLK);

        // Response backpressure: six reads with resp_en held low.
        bus.write_rdy = 1'b0;
        bus.read_rdy  = 1'b1;
        bus.resp_en   = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive(1'b1, 1'b1, 3'(c), 1'b0);
            else       drive(1'b0, 1'b0, 3'd0, 1'b0);
            bus.read_data = 1'(c);
            #1;
            if (bus.read_en) pulses++;
            @(negedge CLK);
        end
        check("bp_read_pulses", 8'(pulses), 8'd4);
        #1;
        check("bp_stall_ren", bus.read_en, 8'd0);
        check("bp_resp_addr", bus.resp_address, 8'd0);
        bus.resp_en = 1'b1;
        #1;
        check("bp_pop_cycle_ren", bus.read_en, 8'd0);
        @(negedge CLK);
        bus.resp_en = 1'b0;
        #1;
        check("bp_fifth_ren", bus.read_en, 8'd1);
        check("bp_fifth_raddr", bus.read_address, 8'd4);
        check("bp_next_resp_addr", bus.resp_address, 8'd1);
        @(negedge CLK);
        #1;
        check("bp_restall_ren", bus.read_en, 8'd0);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        bus.read_rdy = 1'b0;

`ifdef DUT_DRIVER_STATS_EN
        // 300 writes saturate wr_count; no reads since the last reset.
        bus.write_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 3'(i), 1'b0);
            @(negedge CLK);
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("stats_wr_count", wr_count, 8'd255);
        check("stats_rd_count", rd_count, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
